// File: rtl/code_loader_if.sv
// ----------------------------------------------------------------------------
// code_loader_if
// Bundles the signals of the code loader other than clock and reset.
//   Byte stream : rx_valid / rx_data in, rx_ready out (transfer on
//                 rx_valid & rx_ready at a rising clock edge)
//   Code memory : mem_we, mem_addr (word address), mem_wd (32-bit word)
//   Status      : cpu_resetn (active-low CPU reset), busy, done, err
// Modports:
//   slave  - the loader itself (consumes bytes, drives memory and status)
//   master - the byte source / system side
// ----------------------------------------------------------------------------
interface code_loader_if #(
   parameter int ADDR_WIDTH = 9
) ();

   logic                  rx_valid;
   logic [7:0]            rx_data;
   logic                  rx_ready;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wd;
   logic                  cpu_resetn;
   logic                  busy;
   logic                  done;
   logic                  err;

   modport slave (
      input  rx_valid, rx_data,
      output rx_ready, mem_we, mem_addr, mem_wd, cpu_resetn, busy, done, err
   );

   modport master (
      output rx_valid, rx_data,
      input  rx_ready, mem_we, mem_addr, mem_wd, cpu_resetn, busy, done, err
   );

endinterface

// File: rtl/code_loader.sv
// ----------------------------------------------------------------------------
// code_loader
// Receives a framed byte stream and writes it into code memory as 32-bit
// words, holding the CPU in reset until a frame passes its checksum.
//
// Frame: 0xA5, LEN_LO, LEN_HI, LEN x 4 payload bytes (LSB first), CHK,
// where CHK is the XOR of all payload bytes.
//
// Parameters:
//   ADDR_WIDTH - code-memory word-address width (at most 16)
//   TIMEOUT    - idle cycles tolerated between accepted bytes inside a frame
//   BOOT_RUN   - value of cpu_resetn while reset is asserted
// Ports:
//   clk   - rising-edge clock for all state
//   reset - synchronous, active-high reset
//   bus   - code_loader_if.slave: byte stream, memory write port, status
// ----------------------------------------------------------------------------
module code_loader #(
   parameter int ADDR_WIDTH = 9,
   parameter int TIMEOUT    = 65535,
   parameter bit BOOT_RUN   = 1'b0
) (
   input  logic          clk,
   input  logic          reset,
   code_loader_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_PAYLOAD,
      S_WRITE,
      S_CHECK
   } state_t;

   localparam logic [7:0] HDR = 8'hA5;

   // Word index must be able to hold LEN itself, which may equal 2^ADDR_WIDTH.
   localparam int IW = ADDR_WIDTH + 1;
   localparam logic [IW-1:0] IDX_ONE = 1;
   localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_WIDTH);

   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TW:0] TMO_ONE = 1;
   localparam logic [TW:0] TMO_LIM = (TW + 1)'(TIMEOUT);

   state_t          r_state;
   state_t          w_next;

   logic [7:0]      r_len_lo;
   logic [15:0]     r_len;
   logic [1:0]      r_byte_idx;
   logic [IW-1:0]   r_word_idx;
   logic [31:0]     r_word;
   logic [7:0]      r_chk;
   logic [TW-1:0]   r_tmo;
   logic            r_err;
   logic            r_done;
   logic            r_cpu_resetn;

   logic            w_ready;
   logic            w_acc;
   logic [15:0]     w_len_full;
   logic            w_len_big;
   logic            w_len_zero;
   logic            w_last_word;
   logic            w_tmo_active;
   logic [TW:0]     w_tmo_next;
   logic            w_tmo_fire;
   logic            w_start;
   logic            w_set_err;
   logic            w_set_done;

   // ---------------------------------------------------------------------
   // Handshake and decode helpers
   // ---------------------------------------------------------------------
   assign w_ready     = reset || (r_state != S_WRITE);
   assign w_acc       = bus.rx_valid && w_ready;

   // LEN is only complete in the cycle LEN_HI is on the bus.
   assign w_len_full  = {bus.rx_data, r_len_lo};
   assign w_len_big   = {1'b0, w_len_full} > MAX_WORDS;
   assign w_len_zero  = (w_len_full == 16'd0);

   // Evaluated during WRITE, before the index is bumped.
   assign w_last_word = (17'(r_word_idx) + 17'd1) == {1'b0, r_len};

   // The idle counter runs only while waiting for a byte inside a frame;
   // it fires on the edge where it would reach TIMEOUT.
   assign w_tmo_active = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                         (r_state == S_PAYLOAD) || (r_state == S_CHECK);
   assign w_tmo_next   = {1'b0, r_tmo} + TMO_ONE;
   assign w_tmo_fire   = w_tmo_active && !w_acc && (w_tmo_next == TMO_LIM);

   // ---------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of block order.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ---------------------------------------------------------------------
   // FSM next-state and event decode
   // ---------------------------------------------------------------------
   // NOTE: every signal is given a default before the case so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      w_next     = r_state;
      w_start    = 1'b0;
      w_set_err  = 1'b0;
      w_set_done = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            // Anything other than the header is silently dropped.
            if (w_acc && (bus.rx_data == HDR)) begin
               w_next  = S_LEN_LO;
               w_start = 1'b1;
            end
         end
         S_LEN_LO: begin
            if (w_acc) w_next = S_LEN_HI;
         end
         S_LEN_HI: begin
            if (w_acc) begin
               if (w_len_big) begin
                  w_next    = S_IDLE;
                  w_set_err = 1'b1;
               end else if (w_len_zero) begin
                  w_next = S_CHECK;
               end else begin
                  w_next = S_PAYLOAD;
               end
            end
         end
         S_PAYLOAD: begin
            if (w_acc && (r_byte_idx == 2'd3)) w_next = S_WRITE;
         end
         S_WRITE: begin
            w_next = w_last_word ? S_CHECK : S_PAYLOAD;
         end
         S_CHECK: begin
            if (w_acc) begin
               w_next = S_IDLE;
               if (bus.rx_data == r_chk) w_set_done = 1'b1;
               else                      w_set_err  = 1'b1;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase

      if (w_tmo_fire) begin
         w_next    = S_IDLE;
         w_set_err = 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Datapath: length, word assembly, checksum, indices, status
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_len_lo     <= '0;
         r_len        <= '0;
         r_byte_idx   <= '0;
         r_word_idx   <= '0;
         r_word       <= '0;
         r_chk        <= '0;
         r_tmo        <= '0;
         r_err        <= 1'b0;
         r_done       <= 1'b0;
         r_cpu_resetn <= BOOT_RUN;
      end else begin
         r_done <= w_set_done;

         // Release the CPU one edge after the done pulse; a header arriving
         // in that same cycle takes precedence below.
         if (r_done) r_cpu_resetn <= 1'b1;

         if (w_start) begin
            r_err        <= 1'b0;
            r_cpu_resetn <= 1'b0;
            r_chk        <= '0;
            r_byte_idx   <= '0;
            r_word_idx   <= '0;
         end else if (w_set_err) begin
            r_err <= 1'b1;
         end

         if (w_acc || w_tmo_fire) begin
            r_tmo <= '0;
         end else if (w_tmo_active) begin
            r_tmo <= w_tmo_next[TW-1:0];
         end

         if ((r_state == S_LEN_LO) && w_acc) r_len_lo <= bus.rx_data;
         if ((r_state == S_LEN_HI) && w_acc) r_len    <= w_len_full;

         if ((r_state == S_PAYLOAD) && w_acc) begin
            r_word[{r_byte_idx, 3'b000} +: 8] <= bus.rx_data;
            r_chk      <= r_chk ^ bus.rx_data;
            r_byte_idx <= r_byte_idx + 2'd1;   // wraps to 0 after the 4th byte
         end

         if (r_state == S_WRITE) r_word_idx <= r_word_idx + IDX_ONE;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs; forced to their reset values while reset is held so a frame
   // aborted by reset cannot emit another write strobe.
   // ---------------------------------------------------------------------
   assign bus.rx_ready   = w_ready;
   assign bus.mem_we     = !reset && (r_state == S_WRITE);
   assign bus.mem_addr   = reset ? '0 : r_word_idx[ADDR_WIDTH-1:0];
   assign bus.mem_wd     = reset ? '0 : r_word;
   assign bus.cpu_resetn = reset ? BOOT_RUN : r_cpu_resetn;
   assign bus.busy       = !reset && (r_state != S_IDLE);
   assign bus.done       = !reset && r_done;
   assign bus.err        = !reset && r_err;

endmodule

// File: tb/tb_code_loader.sv
// ----------------------------------------------------------------------------
// tb_code_loader
// Self-checking bench for code_loader (ADDR_WIDTH=9, TIMEOUT=8, BOOT_RUN=0).
// A per-cycle vector table drives three back-to-back frames and lists the
// outputs expected during each cycle; hand-written sequences then cover
// reset, oversize LEN, the idle timeout and reset during a write.
// ----------------------------------------------------------------------------
module tb_code_loader;

   localparam int AW = 9;

   // XOR of the eight payload bytes of the two-word test frame (= 0xA1).
   localparam logic [7:0] CHK_GOOD = 8'h00 ^ 8'h00 ^ 8'hC0 ^ 8'h8B ^
                                     8'hFD ^ 8'hFF ^ 8'hFF ^ 8'h17;

   logic clk;
   logic reset;

   code_loader_if #(.ADDR_WIDTH(AW)) bus ();

   code_loader #(
      .ADDR_WIDTH (AW),
      .TIMEOUT    (8),
      .BOOT_RUN   (1'b0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   int we_cnt = 0;

   // Write-strobe monitor, sampled away from the active edge.
   always @(negedge clk) if (bus.mem_we === 1'b1) we_cnt++;

   typedef struct {
      logic          v;
      logic [7:0]    d;
      logic          rdy;
      logic          busy;
      logic          we;
      logic [AW-1:0] addr;
      logic [31:0]   wd;
      logic          done;
      logic          err;
      logic          crn;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic v, input logic [7:0] d,
                               input logic rdy, input logic busy,
                               input logic we, input logic [AW-1:0] addr,
                               input logic [31:0] wd, input logic done,
                               input logic err, input logic crn);
      vec_t t;
      t.v = v; t.d = d; t.rdy = rdy; t.busy = busy; t.we = we;
      t.addr = addr; t.wd = wd; t.done = done; t.err = err; t.crn = crn;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] d);
      @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_data  = d;
   endtask

   task automatic idle_bus();
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   int base;

   initial begin
      reset        = 1'b1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;

      //            v  d      rdy busy we addr wd            done err crn
      // Junk before the header, then a good two-word frame with rx_valid
      // held through both WRITE cycles.
      vecs.push_back(mk(1, 8'h3C,   1, 0, 0, 0, 32'h0,        0, 0, 0));
      vecs.push_back(mk(1, 8'h7E,   1, 0, 0, 0, 32'h0,        0, 0, 0));
      vecs.push_back(mk(1, 8'hA5,   1, 0, 0, 0, 32'h0,        0, 0, 0));
      vecs.push_back(mk(1, 8'h02,   1, 1, 0, 0, 32'h0,        0, 0, 0));
      vecs.push_back(mk(1, 8'h00,   1, 1, 0, 0, 32'h0,        0, 0, 0));
      vecs.push_back(mk(1, 8'h00,   1, 1, 0, 0, 32'h0,        0, 0, 0));
      vecs.push_back(mk(1, 8'h00,   1, 1, 0, 0, 32'h0,        0, 0, 0));
      vecs.push_back(mk(1, 8'hC0,   1, 1, 0, 0, 32'h0,        0, 0, 0));
      vecs.push_back(mk(1, 8'h8B,   1, 1, 0, 0, 32'h0,        0, 0, 0));
      vecs.push_back(mk(1, 8'hFD,   0, 1, 1, 0, 32'h8BC00000, 0, 0, 0));
      vecs.push_back(mk(1, 8'hFD,   1, 1, 0, 0, 32'h0,        0, 0, 0));
      vecs.push_back(mk(1, 8'hFF,   1, 1, 0, 0, 32'h0,        0, 0, 0));
      vecs.push_back(mk(1, 8'hFF,   1, 1, 0, 0, 32'h0,        0, 0, 0));
      vecs.push_back(mk(1, 8'h17,   1, 1, 0, 0, 32'h0,        0, 0, 0));
      vecs.push_back(mk(1, CHK_GOOD,0, 1, 1, 1, 32'h17FFFFFD, 0, 0, 0));
      vecs.push_back(mk(1, CHK_GOOD,1, 1, 0, 0, 32'h0,        0, 0, 0));
      vecs.push_back(mk(0, 8'h00,   1, 0, 0, 0, 32'h0,        1, 0, 0));
      vecs.push_back(mk(0, 8'h00,   1, 0, 0, 0, 32'h0,        0, 0, 1));
      // Same frame with a wrong checksum; rx_valid dropped in first WRITE.
      vecs.push_back(mk(1, 8'hA5,   1, 0, 0, 0, 32'h0,        0, 0, 1));
      vecs.push_back(mk(1, 8'h02,   1, 1, 0, 0, 32'h0,        0, 0, 0));
      vecs.push_back(mk(1, 8'h00,   1, 1, 0, 0, 32'h0,        0, 0, 0));
      vecs.push_back(mk(1, 8'h00,   1, 1, 0, 0, 32'h0,        0, 0, 0));
      vecs.push_back(mk(1, 8'h00,   1, 1, 0, 0, 32'h0,        0, 0, 0));
      vecs.push_back(mk(1, 8'hC0,   1, 1, 0, 0, 32'h0,        0, 0, 0));
      vecs.push_back(mk(1, 8'h8B,   1, 1, 0, 0, 32'h0,        0, 0, 0));
      vecs.push_back(mk(0, 8'h00,   0, 1, 1, 0, 32'h8BC00000, 0, 0, 0));
      vecs.push_back(mk(1, 8'hFD,   1, 1, 0, 0, 32'h0,        0, 0, 0));
      vecs.push_back(mk(1, 8'hFF,   1, 1, 0, 0, 32'h0,        0, 0, 0));
      vecs.push_back(mk(1, 8'hFF,   1, 1, 0, 0, 32'h0,        0, 0, 0));
      vecs.push_back(mk(1, 8'h17,   1, 1, 0, 0, 32'h0,        0, 0, 0));
      vecs.push_back(mk(1, 8'h00,   0, 1, 1, 1, 32'h17FFFFFD, 0, 0, 0));
      vecs.push_back(mk(1, 8'h00,   1, 1, 0, 0, 32'h0,        0, 0, 0));
      vecs.push_back(mk(0, 8'h00,   1, 0, 0, 0, 32'h0,        0, 1, 0));
      vecs.push_back(mk(0, 8'h00,   1, 0, 0, 0, 32'h0,        0, 1, 0));
      // LEN = 0 frame: straight to CHECK, checksum 0x00; then a new header.
      vecs.push_back(mk(1, 8'hA5,   1, 0, 0, 0, 32'h0,        0, 1, 0));
      vecs.push_back(mk(1, 8'h00,   1, 1, 0, 0, 32'h0,        0, 0, 0));
      vecs.push_back(mk(1, 8'h00,   1, 1, 0, 0, 32'h0,        0, 0, 0));
      vecs.push_back(mk(1, 8'h00,   1, 1, 0, 0, 32'h0,        0, 0, 0));
      vecs.push_back(mk(0, 8'h00,   1, 0, 0, 0, 32'h0,        1, 0, 0));
      vecs.push_back(mk(0, 8'h00,   1, 0, 0, 0, 32'h0,        0, 0, 1));
      vecs.push_back(mk(1, 8'hA5,   1, 0, 0, 0, 32'h0,        0, 0, 1));
      vecs.push_back(mk(0, 8'h00,   1, 1, 0, 0, 32'h0,        0, 0, 0));

      // ---- reset state ----
      @(negedge clk);
      @(negedge clk);
      #1;
      check("rst.rx_ready",   32'(bus.rx_ready),   32'd1);
      check("rst.busy",       32'(bus.busy),       32'd0);
      check("rst.mem_we",     32'(bus.mem_we),     32'd0);
      check("rst.done",       32'(bus.done),       32'd0);
      check("rst.err",        32'(bus.err),        32'd0);
      check("rst.cpu_resetn", 32'(bus.cpu_resetn), 32'd0);
      check("rst.mem_addr",   32'(bus.mem_addr),   32'd0);
      check("rst.mem_wd",     bus.mem_wd,          32'd0);

      // ---- vector table ----
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         reset        = 1'b0;
         bus.rx_valid = vecs[i].v;
         bus.rx_data  = vecs[i].d;
         #1;
         check($sformatf("v%0d.rx_ready", i),   32'(bus.rx_ready),   32'(vecs[i].rdy));
         check($sformatf("v%0d.busy", i),       32'(bus.busy),       32'(vecs[i].busy));
         check($sformatf("v%0d.mem_we", i),     32'(bus.mem_we),     32'(vecs[i].we));
         check($sformatf("v%0d.done", i),       32'(bus.done),       32'(vecs[i].done));
         check($sformatf("v%0d.err", i),        32'(bus.err),        32'(vecs[i].err));
         check($sformatf("v%0d.cpu_resetn", i), 32'(bus.cpu_resetn), 32'(vecs[i].crn));
         if (vecs[i].we) begin
            check($sformatf("v%0d.mem_addr", i), 32'(bus.mem_addr), 32'(vecs[i].addr));
            check($sformatf("v%0d.mem_wd", i),   bus.mem_wd,        vecs[i].wd);
         end
      end

      // ---- reset while in LEN_LO ----
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst2.busy",       32'(bus.busy),       32'd0);
      check("rst2.rx_ready",   32'(bus.rx_ready),   32'd1);
      check("rst2.cpu_resetn", 32'(bus.cpu_resetn), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst2.idle", 32'(bus.busy), 32'd0);

      // ---- LEN = 513 exceeds 512 words ----
      base = we_cnt;
      send(8'hA5);
      send(8'h01);
      send(8'h02);
      idle_bus();
      check("ovf.err",        32'(bus.err),        32'd1);
      check("ovf.busy",       32'(bus.busy),       32'd0);
      check("ovf.cpu_resetn", 32'(bus.cpu_resetn), 32'd0);
      check("ovf.no_we",      32'(we_cnt - base),  32'd0);

      // ---- idle timeout: err exactly 8 cycles after last accepted byte ----
      send(8'hA5);
      send(8'h01);
      send(8'h00);
      send(8'h11);
      idle_bus();
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         #1;
         check($sformatf("tmo%0d.err", k),  32'(bus.err),  32'(k == 8));
         check($sformatf("tmo%0d.busy", k), 32'(bus.busy), 32'(k != 8));
      end
      check("tmo.cpu_resetn", 32'(bus.cpu_resetn), 32'd0);

      // ---- reset asserted during a WRITE cycle ----
      send(8'hA5);
      send(8'h01);
      send(8'h00);
      send(8'h11);
      send(8'h22);
      send(8'h33);
      send(8'h44);
      idle_bus();
      check("rw.pre_we", 32'(bus.mem_we), 32'd1);
      check("rw.pre_wd", bus.mem_wd,      32'h44332211);
      reset = 1'b1;
      #1;
      check("rw.we_in_reset",   32'(bus.mem_we), 32'd0);
      check("rw.busy_in_reset", 32'(bus.busy),   32'd0);
      @(negedge clk);
      reset = 1'b0;
      base  = we_cnt;
      repeat (3) @(negedge clk);
      #1;
      check("rw.no_we_after", 32'(we_cnt - base), 32'd0);
      check("rw.idle_after",  32'(bus.busy),      32'd0);
      check("rw.err_after",   32'(bus.err),       32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
